memory_bus_arbiter: RTL and testbench

MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

---
 rtl/glasscell_pkg.sv | 22 ++
 rtl/rr_priority_select.sv | 38 +++
 rtl/memory_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_memory_bus_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/glasscell_pkg.sv
// glasscell_pkg: shared types for the memory bus arbiter (transfer size, arbiter state).
package glasscell_pkg;

  localparam int unsigned DW_BITS = 2;

  typedef enum logic [DW_BITS-1:0] {
    DW_BYTE = 2'd0,
    DW_HALF = 2'd1,
    DW_WORD = 2'd2
  } data_width_e;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  // Index width for an N-entry vector; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: picks the first set request at or after the pointer, wrapping N-1 -> 0.
module rr_priority_select
  import glasscell_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] winner_o,
  output logic          valid_o
);

  logic [2*N-1:0] dbl_c;
  logic [N-1:0]   rot_c;
  logic [IW:0]    sum_c;

  // Rotate so the pointer position sits at bit 0, then scan downward so the
  // lowest rotated offset (closest to the pointer) is the last write and wins.
  always_comb begin
    dbl_c    = {req_i, req_i} >> ptr_i;
    rot_c    = dbl_c[N-1:0];
    sum_c    = '0;
    winner_o = '0;
    valid_o  = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot_c[k]) begin
        sum_c = {1'b0, ptr_i} + (IW+1)'(k);
        if (sum_c >= (IW+1)'(N)) begin
          sum_c = sum_c - (IW+1)'(N);
        end
        winner_o = sum_c[IW-1:0];
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: round-robin arbiter giving one of MASTERS bus masters
// ownership of a single memory port for the whole of its bus cycle.
// Optional watchdog that aborts stuck cycles: define ARBITER_WATCHDOG_EN.
module memory_bus_arbiter
  import glasscell_pkg::*;
#(
  parameter int unsigned MASTERS        = 2,
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [MASTERS-1:0]               MasterCycle_i,
  input  logic [MASTERS-1:0]               MasterStrobe_i,
  input  logic [MASTERS-1:0]               MasterReadWrite_i,
  input  logic [DW_BITS*MASTERS-1:0]       MasterDataWidth_i,
  input  logic [ADDRESS_WIDTH*MASTERS-1:0] MasterAddress_i,
  input  logic [DATA_WIDTH*MASTERS-1:0]    MasterDataIn_i,
  output logic [DATA_WIDTH-1:0]            MasterDataOut_o,
  output logic [MASTERS-1:0]               MasterAcknowledge_o,
  output logic [MASTERS-1:0]               MasterStall_o,
  output logic [MASTERS-1:0]               MasterError_o,
  output logic                             MemoryCycle_o,
  output logic                             MemoryStrobe_o,
  output logic                             MemoryReadWrite_o,
  output logic [DW_BITS-1:0]               MemoryDataWidth_o,
  output logic [ADDRESS_WIDTH-1:0]         MemoryAddress_o,
  output logic [DATA_WIDTH-1:0]            MemoryDataOut_o,
  input  logic [DATA_WIDTH-1:0]            MemoryDataIn_i,
  input  logic                             MemoryAcknowledge_i,
  input  logic                             MemoryStall_i
);

  localparam int unsigned IW = idx_width(MASTERS);

  // Elaboration-time guard on the supported configuration range.
  if (MASTERS < 2 || MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("memory_bus_arbiter: MASTERS must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_e    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] winner_c;
  logic          win_valid_c;
  logic [IW-1:0] grant_inc_c;
  logic          owned_c;
  logic          timeout_c;

  assign owned_c         = (state_q == ARB_OWNED);
  assign grant_inc_c     = (grant_q == IW'(MASTERS - 1)) ? '0 : grant_q + IW'(1);
  assign MasterDataOut_o = MemoryDataIn_i;

  rr_priority_select #(
    .N  (MASTERS),
    .IW (IW)
  ) u_rr_select (
    .req_i    (MasterCycle_i),
    .ptr_i    (ptr_q),
    .winner_o (winner_c),
    .valid_o  (win_valid_c)
  );

`ifdef ARBITER_WATCHDOG_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wdog_q, wdog_d;

  assign timeout_c = owned_c && (wdog_q == CW'(TIMEOUT_CYCLES));

  // Count owned cycles without an acknowledge; zero whenever ownership starts or ends.
  always_comb begin
    wdog_d = '0;
    if (owned_c && (state_d == ARB_OWNED) && !MemoryAcknowledge_i) begin
      wdog_d = wdog_q + CW'(1);
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  // Arbitration FSM next state: grant in IDLE, hold until release or timeout.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (win_valid_c) begin
          state_d = ARB_OWNED;
          grant_d = winner_c;
        end
      end
      ARB_OWNED: begin
        if (timeout_c || !MasterCycle_i[grant_q]) begin
          state_d = ARB_IDLE;
          ptr_d   = grant_inc_c;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // Forward the owner's request to memory and route the handshake back to it;
  // every other requester is held off with a stall.
  always_comb begin
    MemoryCycle_o       = 1'b0;
    MemoryStrobe_o      = 1'b0;
    MemoryReadWrite_o   = 1'b0;
    MemoryDataWidth_o   = '0;
    MemoryAddress_o     = '0;
    MemoryDataOut_o     = '0;
    MasterAcknowledge_o = '0;
    MasterStall_o       = '0;
    MasterError_o       = '0;
    if (rst_n) begin
      MasterStall_o = MasterCycle_i;
      if (owned_c) begin
        MemoryCycle_o                = MasterCycle_i[grant_q];
        MemoryStrobe_o               = MasterStrobe_i[grant_q];
        MemoryReadWrite_o            = MasterReadWrite_i[grant_q];
        MemoryDataWidth_o            = MasterDataWidth_i[grant_q*DW_BITS +: DW_BITS];
        MemoryAddress_o              = MasterAddress_i[grant_q*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        MemoryDataOut_o              = MasterDataIn_i[grant_q*DATA_WIDTH +: DATA_WIDTH];
        MasterStall_o[grant_q]       = MemoryStall_i;
        MasterAcknowledge_o[grant_q] = MemoryAcknowledge_i;
        MasterError_o[grant_q]       = timeout_c;
      end
    end
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// tb_memory_bus_arbiter: directed checks on a 2-master and a 4-master arbiter.
module tb_memory_bus_arbiter;
  import glasscell_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- 2-master instance ----------------
  logic          a_rst_n;
  logic [1:0]    a_cyc, a_stb, a_rw;
  logic [3:0]    a_dw;
  logic [63:0]   a_addr, a_wdata;
  logic [31:0]   a_dout;
  logic [1:0]    a_ack, a_stall, a_err;
  logic          a_mcyc, a_mstb, a_mrw;
  logic [1:0]    a_mdw;
  logic [31:0]   a_maddr, a_mwdata, a_mrdata;
  logic          a_mack, a_mstall;

  memory_bus_arbiter #(
    .MASTERS(2), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) u_dut2 (
    .clk(clk), .rst_n(a_rst_n),
    .MasterCycle_i(a_cyc), .MasterStrobe_i(a_stb), .MasterReadWrite_i(a_rw),
    .MasterDataWidth_i(a_dw), .MasterAddress_i(a_addr), .MasterDataIn_i(a_wdata),
    .MasterDataOut_o(a_dout), .MasterAcknowledge_o(a_ack), .MasterStall_o(a_stall),
    .MasterError_o(a_err), .MemoryCycle_o(a_mcyc), .MemoryStrobe_o(a_mstb),
    .MemoryReadWrite_o(a_mrw), .MemoryDataWidth_o(a_mdw), .MemoryAddress_o(a_maddr),
    .MemoryDataOut_o(a_mwdata), .MemoryDataIn_i(a_mrdata),
    .MemoryAcknowledge_i(a_mack), .MemoryStall_i(a_mstall)
  );

  // ---------------- 4-master instance ----------------
  logic          b_rst_n;
  logic [3:0]    b_cyc, b_stb, b_rw;
  logic [7:0]    b_dw;
  logic [127:0]  b_addr, b_wdata;
  logic [31:0]   b_dout;
  logic [3:0]    b_ack, b_stall, b_err;
  logic          b_mcyc, b_mstb, b_mrw;
  logic [1:0]    b_mdw;
  logic [31:0]   b_maddr, b_mwdata, b_mrdata;
  logic          b_mack, b_mstall;

  memory_bus_arbiter #(
    .MASTERS(4), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) u_dut4 (
    .clk(clk), .rst_n(b_rst_n),
    .MasterCycle_i(b_cyc), .MasterStrobe_i(b_stb), .MasterReadWrite_i(b_rw),
    .MasterDataWidth_i(b_dw), .MasterAddress_i(b_addr), .MasterDataIn_i(b_wdata),
    .MasterDataOut_o(b_dout), .MasterAcknowledge_o(b_ack), .MasterStall_o(b_stall),
    .MasterError_o(b_err), .MemoryCycle_o(b_mcyc), .MemoryStrobe_o(b_mstb),
    .MemoryReadWrite_o(b_mrw), .MemoryDataWidth_o(b_mdw), .MemoryAddress_o(b_maddr),
    .MemoryDataOut_o(b_mwdata), .MemoryDataIn_i(b_mrdata),
    .MemoryAcknowledge_i(b_mack), .MemoryStall_i(b_mstall)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Row: inputs for one cycle, then the owner (0 none, 1 master0, 2 master1)
  // and expected handshake outputs during that cycle.
  typedef struct {
    logic [1:0]  cyc;
    logic        mack;
    logic        mstall;
    logic [31:0] rdata;
    int          own;
    logic        exp_mcyc;
    logic [1:0]  exp_ack;
    logic [1:0]  exp_stall;
  } vec2_t;

  localparam int NV = 17;
  vec2_t tbl[NV];

  logic [31:0] e_addr, e_wdata;
  logic        e_rw, e_stb;
  logic [1:0]  e_dw;
  int          order[5];
  logic [3:0]  oh;

  initial begin
    tbl[0]  = '{2'b01, 1'b0, 1'b0, 32'h0000_0011, 0, 1'b0, 2'b00, 2'b01};
    tbl[1]  = '{2'b11, 1'b0, 1'b0, 32'h0000_0022, 1, 1'b1, 2'b00, 2'b10};
    tbl[2]  = '{2'b11, 1'b1, 1'b0, 32'hDEAD_BEEF, 1, 1'b1, 2'b01, 2'b10};
    tbl[3]  = '{2'b11, 1'b0, 1'b1, 32'h0000_0033, 1, 1'b1, 2'b00, 2'b11};
    tbl[4]  = '{2'b10, 1'b0, 1'b0, 32'h0000_0000, 1, 1'b0, 2'b00, 2'b10};
    tbl[5]  = '{2'b10, 1'b0, 1'b0, 32'h0000_0000, 0, 1'b0, 2'b00, 2'b10};
    tbl[6]  = '{2'b10, 1'b0, 1'b0, 32'h0000_0000, 2, 1'b1, 2'b00, 2'b00};
    tbl[7]  = '{2'b11, 1'b1, 1'b0, 32'h0000_0044, 2, 1'b1, 2'b10, 2'b01};
    tbl[8]  = '{2'b01, 1'b0, 1'b0, 32'h0000_0000, 2, 1'b0, 2'b00, 2'b01};
    tbl[9]  = '{2'b01, 1'b0, 1'b0, 32'h0000_0000, 0, 1'b0, 2'b00, 2'b01};
    tbl[10] = '{2'b01, 1'b0, 1'b0, 32'h0000_0000, 1, 1'b1, 2'b00, 2'b00};
    tbl[11] = '{2'b00, 1'b0, 1'b0, 32'h0000_0000, 1, 1'b0, 2'b00, 2'b00};
    tbl[12] = '{2'b00, 1'b0, 1'b0, 32'h0000_0000, 0, 1'b0, 2'b00, 2'b00};
    tbl[13] = '{2'b11, 1'b0, 1'b0, 32'h0000_0000, 0, 1'b0, 2'b00, 2'b11};
    tbl[14] = '{2'b11, 1'b0, 1'b0, 32'h0000_0000, 2, 1'b1, 2'b00, 2'b01};
    tbl[15] = '{2'b00, 1'b0, 1'b0, 32'h0000_0000, 2, 1'b0, 2'b00, 2'b00};
    tbl[16] = '{2'b00, 1'b1, 1'b1, 32'h0000_0055, 0, 1'b0, 2'b00, 2'b00};

    // Master 0: word read of 0x100; master 1: byte write of 0x200.
    a_stb   = 2'b11;
    a_rw    = 2'b10;
    a_dw    = {2'(DW_BYTE), 2'(DW_WORD)};
    a_addr  = {32'h0000_0200, 32'h0000_0100};
    a_wdata = {32'hB1B1_1111, 32'hA0A0_0000};
    b_stb   = 4'hF;
    b_rw    = 4'h0;
    b_dw    = 8'h00;
    b_addr  = {32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    b_wdata = '0;
    b_mrdata = 32'h0BAD_F00D;
    b_mack = 1'b0; b_mstall = 1'b0;

    // Reset: requests and memory handshake active, every output must stay low.
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_cyc = 2'b11; a_mack = 1'b1; a_mstall = 1'b1; a_mrdata = 32'h1234_5678;
    b_cyc = 4'hF;
    tick(); tick();
    check("rst mcyc",  32'(a_mcyc),  32'h0);
    check("rst mstb",  32'(a_mstb),  32'h0);
    check("rst maddr", a_maddr,      32'h0);
    check("rst ack",   32'(a_ack),   32'h0);
    check("rst stall", 32'(a_stall), 32'h0);
    check("rst err",   32'(a_err),   32'h0);
    check("rst dout",  a_dout,       32'h1234_5678);
    check("rst4 stall", 32'(b_stall), 32'h0);

    a_rst_n = 1'b1; b_rst_n = 1'b1;
    b_cyc = 4'h0;

    // 2-master table.
    for (int i = 0; i < NV; i++) begin
      a_cyc    = tbl[i].cyc;
      a_mack   = tbl[i].mack;
      a_mstall = tbl[i].mstall;
      a_mrdata = tbl[i].rdata;
      e_stb    = (tbl[i].own != 0);
      e_addr   = (tbl[i].own == 1) ? 32'h100 : (tbl[i].own == 2) ? 32'h200 : 32'h0;
      e_wdata  = (tbl[i].own == 1) ? 32'hA0A0_0000 : (tbl[i].own == 2) ? 32'hB1B1_1111 : 32'h0;
      e_rw     = (tbl[i].own == 2);
      e_dw     = (tbl[i].own == 1) ? 2'(DW_WORD) : 2'(DW_BYTE);
      #1;
      check($sformatf("r%0d mcyc", i),   32'(a_mcyc),   32'(tbl[i].exp_mcyc));
      check($sformatf("r%0d mstb", i),   32'(a_mstb),   32'(e_stb));
      check($sformatf("r%0d maddr", i),  a_maddr,       e_addr);
      check($sformatf("r%0d mwdata", i), a_mwdata,      e_wdata);
      check($sformatf("r%0d mrw", i),    32'(a_mrw),    32'(e_rw));
      check($sformatf("r%0d mdw", i),    32'(a_mdw),    32'(e_dw));
      check($sformatf("r%0d ack", i),    32'(a_ack),    32'(tbl[i].exp_ack));
      check($sformatf("r%0d stall", i),  32'(a_stall),  32'(tbl[i].exp_stall));
      check($sformatf("r%0d dout", i),   a_dout,        tbl[i].rdata);
      check($sformatf("r%0d err", i),    32'(a_err),    32'h0);
      tick();
    end

    // 4 masters requesting continuously, each owning 3 cycles: order 0,1,2,3,0.
    order = '{0, 1, 2, 3, 0};
    b_cyc = 4'hF;
    for (int g = 0; g < 5; g++) begin
      oh = 4'(1) << order[g];
      #1;
      check($sformatf("rr%0d idle mcyc", g), 32'(b_mcyc), 32'h0);
      check($sformatf("rr%0d idle stall", g), 32'(b_stall), 32'hF);
      tick();
      for (int h = 0; h < 3; h++) begin
        #1;
        check($sformatf("rr%0d.%0d mcyc", g, h), 32'(b_mcyc), 32'h1);
        check($sformatf("rr%0d.%0d maddr", g, h), b_maddr, 32'(32'h1000 * (order[g] + 1)));
        check($sformatf("rr%0d.%0d stall", g, h), 32'(b_stall), 32'(4'hF & ~oh));
        tick();
      end
      b_cyc = 4'hF & ~oh;
      #1;
      check($sformatf("rr%0d rel mcyc", g), 32'(b_mcyc), 32'h0);
      tick();
      b_cyc = 4'hF;
    end

    // Pointer now 1: a lone request from master 2 is granted.
    b_cyc = 4'b0100;
    tick();
    #1;
    check("m2 own maddr", b_maddr, 32'h3000);
    tick();
    // Asynchronous reset mid-ownership.
    #1;
    b_mack = 1'b1;
    b_rst_n = 1'b0;
    #1;
    check("arst mcyc",  32'(b_mcyc),  32'h0);
    check("arst maddr", b_maddr,      32'h0);
    check("arst ack",   32'(b_ack),   32'h0);
    check("arst stall", 32'(b_stall), 32'h0);
    check("arst err",   32'(b_err),   32'h0);
    check("arst dout",  b_dout,       32'h0BAD_F00D);
    tick();
    b_rst_n = 1'b1;
    b_mack = 1'b0;
    b_cyc = 4'hF;
    #1;
    check("post rst idle", 32'(b_mcyc), 32'h0);
    tick();
    #1;
    check("post rst grant0", b_maddr, 32'h1000);
    b_cyc = 4'h0;
    tick();
    tick();

    // Master 2 alone, memory never acknowledges.
    b_cyc = 4'b0100;
    #1;
    check("wd idle mcyc", 32'(b_mcyc), 32'h0);
    tick();
`ifdef ARBITER_WATCHDOG_EN
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("wd c%0d mcyc", k), 32'(b_mcyc), 32'h1);
      check($sformatf("wd c%0d err", k), 32'(b_err), 32'h0);
      tick();
    end
    #1;
    check("wd timeout err", 32'(b_err), 32'h4);
    check("wd timeout mcyc", 32'(b_mcyc), 32'h1);
    tick();
    #1;
    check("wd abort mcyc", 32'(b_mcyc), 32'h0);
    check("wd abort err", 32'(b_err), 32'h0);
    check("wd abort stall", 32'(b_stall), 32'h4);
    tick();
    #1;
    check("wd regrant maddr", b_maddr, 32'h3000);
`else
    for (int k = 0; k < 20; k++) begin
      #1;
      check($sformatf("nowd c%0d mcyc", k), 32'(b_mcyc), 32'h1);
      check($sformatf("nowd c%0d err", k), 32'(b_err), 32'h0);
      tick();
    end
`endif
    b_cyc = 4'h0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
